// File: rtl/disp_pkg.sv
// Shared types and constants for the vending-machine display scheduler.
package disp_pkg;

    localparam int unsigned BCD_W    = 12;
    localparam int unsigned MAX_DISP = 999;

    localparam logic [3:0] NIB_C = 4'hC;
    localparam logic [3:0] NIB_E = 4'hE;

    typedef enum logic [1:0] {
        VIEW_BAL   = 2'd0,
        VIEW_PRICE = 2'd1,
        VIEW_ALERT = 2'd2
    } view_t;

    typedef enum logic [1:0] {
        CV_IDLE  = 2'd0,
        CV_SHIFT = 2'd1,
        CV_DONE  = 2'd2
    } cv_state_t;

    // Display payload handed to the scan/decode block; d0 is the rightmost digit.
    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [3:0] blank;
    } disp_t;

    localparam disp_t DISP_RST = '{d3: 4'h0, d2: 4'h0, d1: 4'h0, d0: 4'h0, blank: 4'b1110};

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 3-digit BCD converter (load, VAL_W shifts, done).
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int unsigned VAL_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    input  logic             abort,
    output logic [BCD_W-1:0] bcd,
    output logic             ovf,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(VAL_W + 1);

    cv_state_t        state;
    cv_state_t        state_nxt;
    logic [VAL_W-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic             load_c;
    logic             last_c;
    logic             done_nxt;
    logic             busy_nxt;

    // An abort with start present reloads straight away so a restart costs no extra cycle.
    assign load_c = start && (abort || (state == CV_IDLE));
    assign last_c = (cnt == CNT_W'(VAL_W - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = start ? CV_SHIFT : CV_IDLE;
        end else begin
            case (state)
                CV_IDLE:  if (start) state_nxt = CV_SHIFT;
                CV_SHIFT: if (last_c) state_nxt = CV_DONE;
                CV_DONE:  state_nxt = CV_IDLE;
                default:  state_nxt = CV_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the flags register in step with it
    always_comb begin
        done_nxt = (state_nxt == CV_DONE);
        busy_nxt = (state_nxt == CV_SHIFT) || (state_nxt == CV_DONE);
    end

    // Registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= done_nxt;
            busy <= busy_nxt;
        end
    end

    // Shift/accumulate datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            bcd <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (load_c) begin
            sh  <= bin;
            bcd <= '0;
            cnt <= '0;
            ovf <= (32'(bin) > MAX_DISP);
        end else if ((state == CV_SHIFT) && !abort) begin
            {bcd, sh} <= {add3(bcd), sh} << 1;
            cnt       <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/disp_scheduler.sv
// Chooses balance / price / alert view for the 4-digit display and formats its digits.
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned PRICE_MS = 1500,
    parameter int unsigned ALERT_MS = 2000,
    parameter int unsigned VAL_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VAL_W-1:0] bal_value,
    input  logic             price_req,
    input  logic [VAL_W-1:0] price_value,
    input  logic             alert_req,
    input  logic [3:0]       alert_code,
    output logic [3:0]       digit0,
    output logic [3:0]       digit1,
    output logic [3:0]       digit2,
    output logic [3:0]       digit3,
    output logic [3:0]       digit_blank,
    output logic [1:0]       view,
    output logic             conv_busy
);

    localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_MAX = (PRICE_MS > ALERT_MS) ? PRICE_MS : ALERT_MS;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    view_t             st;
    view_t             st_nxt;
    logic [DIV_W-1:0]  div_q;
    logic              tick_c;
    logic [HOLD_W-1:0] hold_q;
    logic              expire_c;
    logic              enter_price_c;
    logic              pend_q;
    logic [VAL_W-1:0]  price_q;
    logic [3:0]        code_q;
    disp_t             disp_q;
    disp_t             disp_nxt;
    logic              conv_start;
    logic              conv_abort;
    logic [VAL_W-1:0]  conv_bin;
    logic [BCD_W-1:0]  conv_bcd;
    logic              conv_ovf;
    logic              conv_done;

    assign tick_c   = (div_q == DIV_W'(TICK_DIV - 1));
    assign expire_c = tick_c && (hold_q == HOLD_W'(1));

    assign view        = st;
    assign digit3      = disp_q.d3;
    assign digit2      = disp_q.d2;
    assign digit1      = disp_q.d1;
    assign digit0      = disp_q.d0;
    assign digit_blank = disp_q.blank;

    // Free-running 1 ms tick divider, never disturbed by view changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick_c) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // View state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= VIEW_BAL;
        end else begin
            st <= st_nxt;
        end
    end

    // View next-state: alerts pre-empt everything, timed views fall back on expiry
    always_comb begin
        st_nxt = st;
        if (alert_req) begin
            st_nxt = VIEW_ALERT;
        end else begin
            case (st)
                VIEW_BAL:   if (price_req) st_nxt = VIEW_PRICE;
                VIEW_PRICE: if (!price_req && expire_c) st_nxt = VIEW_BAL;
                VIEW_ALERT: if (expire_c) st_nxt = (pend_q || price_req) ? VIEW_PRICE : VIEW_BAL;
                default:    st_nxt = VIEW_BAL;
            endcase
        end
    end

    // Converter control and next display contents
    always_comb begin
        enter_price_c = (st_nxt == VIEW_PRICE) && ((st != VIEW_PRICE) || price_req);
        conv_start    = (st_nxt == VIEW_BAL) || enter_price_c;
        conv_abort    = (st_nxt != st) || enter_price_c || (st_nxt == VIEW_ALERT);
        conv_bin      = bal_value;
        if (enter_price_c) begin
            conv_bin = price_req ? price_value : price_q;
        end

        disp_nxt = disp_q;
        if (st == VIEW_ALERT) begin
            disp_nxt = '{d3: NIB_E, d2: 4'h0, d1: 4'h0, d0: code_q, blank: 4'b0110};
        end else if (conv_done) begin
            disp_nxt.d3       = (st == VIEW_PRICE) ? NIB_C : 4'h0;
            disp_nxt.blank[3] = (st != VIEW_PRICE);
            if (conv_ovf) begin
                disp_nxt.d2         = NIB_E;
                disp_nxt.d1         = NIB_E;
                disp_nxt.d0         = NIB_E;
                disp_nxt.blank[2:0] = 3'b000;
            end else begin
                disp_nxt.d2       = conv_bcd[11:8];
                disp_nxt.d1       = conv_bcd[7:4];
                disp_nxt.d0       = conv_bcd[3:0];
                disp_nxt.blank[2] = (conv_bcd[11:8] == 4'h0);
                disp_nxt.blank[1] = (conv_bcd[11:8] == 4'h0) && (conv_bcd[7:4] == 4'h0);
                disp_nxt.blank[0] = 1'b0;
            end
        end
    end

    // Hold timer, captured request data and display register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            pend_q  <= 1'b0;
            price_q <= '0;
            code_q  <= '0;
            disp_q  <= DISP_RST;
        end else begin
            if (alert_req) begin
                hold_q <= HOLD_W'(ALERT_MS);
                code_q <= alert_code;
            end else if (enter_price_c) begin
                hold_q <= HOLD_W'(PRICE_MS);
            end else if (tick_c && (hold_q != '0)) begin
                hold_q <= hold_q - HOLD_W'(1);
            end
            if (price_req) begin
                price_q <= price_value;
            end
            pend_q <= (st_nxt == VIEW_ALERT) && (pend_q || price_req);
            disp_q <= disp_nxt;
        end
    end

    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_bin),
        .abort (conv_abort),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf),
        .done  (conv_done),
        .busy  (conv_busy)
    );

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed self-checking bench for disp_scheduler (TICK_DIV=4, PRICE_MS=3, ALERT_MS=5).
module tb_disp_scheduler;

    localparam int unsigned VAL_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [VAL_W-1:0] bal_value;
    logic             price_req;
    logic [VAL_W-1:0] price_value;
    logic             alert_req;
    logic [3:0]       alert_code;
    logic [3:0]       digit0, digit1, digit2, digit3, digit_blank;
    logic [1:0]       view;
    logic             conv_busy;
    logic [19:0]      shown;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int bad;

    always #5 clk = ~clk;

    // Edges since reset release; ticks land on edges that are multiples of 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    assign shown = {digit3, digit2, digit1, digit0, digit_blank};

    disp_scheduler #(
        .TICK_DIV (4),
        .PRICE_MS (3),
        .ALERT_MS (5),
        .VAL_W    (VAL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bal_value   (bal_value),
        .price_req   (price_req),
        .price_value (price_value),
        .alert_req   (alert_req),
        .alert_code  (alert_code),
        .digit0      (digit0),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .digit_blank (digit_blank),
        .view        (view),
        .conv_busy   (conv_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stop at the negedge whose following edge number is congruent to 0 mod 4 when ph=3.
    task automatic wait_phase(input int ph);
        @(negedge clk);
        while ((cyc % 4) != ph) @(negedge clk);
    endtask

    // Count samples that are neither the old nor the new display image.
    task automatic watch(input int n, input logic [19:0] a, input logic [19:0] b, output int nbad);
        nbad = 0;
        repeat (n) begin
            @(negedge clk);
            if ((shown !== a) && (shown !== b)) nbad++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        bal_value   = '0;
        price_req   = 1'b0;
        price_value = '0;
        alert_req   = 1'b0;
        alert_code  = 4'h0;

        // Reset state and first balance conversion
        step(2);
        chk("rst_disp", shown, 20'h0000E);
        chk("rst_view", view, 2'd0);
        chk("rst_busy", conv_busy, 1'b0);
        rst_n = 1'b1;
        step(1);
        chk("busy_e1", conv_busy, 1'b1);
        step(10);
        chk("busy_e11", conv_busy, 1'b1);
        step(1);
        chk("busy_e12", conv_busy, 1'b0);
        chk("bal0", shown, 20'h0000E);
        chk("bal0_view", view, 2'd0);

        // Balance values, including overflow
        bal_value = 10'd7;
        watch(26, 20'h0000E, 20'h0007E, bad);
        chk("bal7_glitch", bad, 0);
        chk("bal7", shown, 20'h0007E);
        bal_value = 10'd305;
        watch(26, 20'h0007E, 20'h03058, bad);
        chk("bal305_glitch", bad, 0);
        chk("bal305", shown, 20'h03058);
        bal_value = 10'd1000;
        watch(26, 20'h03058, 20'h0EEE8, bad);
        chk("bal1000_glitch", bad, 0);
        chk("bal1000", shown, 20'h0EEE8);

        // Price view: 45 requested on a tick edge, expires three ticks later
        wait_phase(3);
        price_req = 1'b1; price_value = 10'd45; bal_value = 10'd12;
        step(1);
        price_req = 1'b0;
        chk("p45_view", view, 2'd1);
        step(10);
        chk("p45_held", shown, 20'h0EEE8);
        step(1);
        chk("p45_disp", shown, 20'hC0454);
        chk("p45_view_e11", view, 2'd1);
        step(1);
        chk("p45_exp", view, 2'd0);
        step(10);
        chk("p45_keep", shown, 20'hC0454);
        step(1);
        chk("bal12", shown, 20'h0012C);

        // Alert during price
        wait_phase(3);
        price_req = 1'b1; price_value = 10'd250;
        step(1);
        price_req = 1'b0;
        alert_req = 1'b1; alert_code = 4'd3;
        step(1);
        alert_req = 1'b0;
        chk("a3_view", view, 2'd2);
        step(1);
        chk("a3_d3", digit3, 4'hE);
        chk("a3_d0", digit0, 4'h3);
        chk("a3_blank", digit_blank, 4'b0110);
        step(3);
        chk("a3_busy", conv_busy, 1'b0);
        step(14);
        chk("a3_hold", view, 2'd2);
        step(1);
        chk("a3_exp", view, 2'd0);

        // Pending price during alert, alert restarted with a new code
        wait_phase(3);
        alert_req = 1'b1; alert_code = 4'd2;
        step(1);
        alert_req = 1'b0;
        price_req = 1'b1; price_value = 10'd90;
        step(1);
        price_req = 1'b0;
        step(7);
        alert_req = 1'b1; alert_code = 4'd4;
        step(1);
        alert_req = 1'b0;
        step(1);
        chk("a4_d0", digit0, 4'h4);
        chk("a4_view", view, 2'd2);
        step(10);
        chk("a4_restart", view, 2'd2);
        step(7);
        chk("a4_hold", view, 2'd2);
        step(1);
        chk("pend_view", view, 2'd1);
        step(10);
        chk("pend_held_d3", digit3, 4'hE);
        chk("pend_held_d0", digit0, 4'h4);
        step(1);
        chk("p90_disp", shown, 20'hC0904);
        step(1);
        chk("p90_exp", view, 2'd0);

        // Asynchronous reset in the middle of a conversion
        bal_value = 10'd305;
        step(1);
        begin
            int n = 0;
            while ((conv_busy !== 1'b0) && (n < 30)) begin
                step(1);
                n++;
            end
        end
        step(3);
        chk("pre_busy", conv_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_disp", shown, 20'h0000E);
        chk("arst_view", view, 2'd0);
        chk("arst_busy", conv_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(11);
        chk("post_e11", shown, 20'h0000E);
        step(1);
        chk("post_305", shown, 20'h03058);

        // Asynchronous reset in the middle of an alert
        alert_req = 1'b1; alert_code = 4'd7;
        step(1);
        alert_req = 1'b0;
        step(3);
        chk("a7_view", view, 2'd2);
        chk("a7_d0", digit0, 4'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst2_disp", shown, 20'h0000E);
        chk("arst2_view", view, 2'd0);
        bal_value = 10'd999;
        @(negedge clk);
        rst_n = 1'b1;
        step(12);
        chk("post_999", shown, 20'h09998);
        chk("post_999_view", view, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
